// File: rtl/neuron_scheduler_if.sv
// Weight-memory and shared-neuron datapath bus of the neuron scheduler.
// master = scheduler side, slave = weight SRAM plus combinational neuron side.
interface neuron_scheduler_if #(
    parameter int SIZE = 8,
    parameter int AW   = 8
);
    logic            weight_ren;
    logic [AW-1:0]   weight_addr;
    logic [SIZE-1:0] weight_rdata;
    logic [SIZE-1:0] dp_weight;
    logic [SIZE-1:0] dp_v_mem_in;
    logic [SIZE-1:0] dp_beta;
    logic [SIZE-1:0] dp_v_th;
    logic            dp_function_sel;
    logic            dp_spike;
    logic [SIZE-1:0] dp_v_mem_out;

    modport master (
        output weight_ren, weight_addr, dp_weight, dp_v_mem_in, dp_beta, dp_v_th, dp_function_sel,
        input  weight_rdata, dp_spike, dp_v_mem_out
    );
    modport slave (
        input  weight_ren, weight_addr, dp_weight, dp_v_mem_in, dp_beta, dp_v_th, dp_function_sel,
        output weight_rdata, dp_spike, dp_v_mem_out
    );
endinterface

// File: rtl/neuron_scheduler.sv
// Runs one SNN timestep of a neuron layer on one shared neuron: integrate every (input, neuron) pair, then decay/fire.
// start->done in 1+2*NUM_INPUTS*NUM_NEURONS+NUM_NEURONS cycles (weight SRAM never stalls); NEURON_SCHED_SKIP_EN skips silent inputs.
module neuron_scheduler #(
    parameter int SIZE        = 8,
    parameter int NUM_INPUTS  = 16,
    parameter int NUM_NEURONS = 10,
    parameter int AW          = $clog2(NUM_INPUTS*NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   clear_vmem,
    input  logic [NUM_INPUTS-1:0]  spikes_in,
    input  logic [SIZE-1:0]        beta,
    input  logic [SIZE-1:0]        v_th,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_NEURONS-1:0] spikes_out,
    neuron_scheduler_if.master     bus
);
    localparam int IW = (NUM_INPUTS  > 1) ? $clog2(NUM_INPUTS)  : 1;
    localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] EXEC  = 3'd2;
    localparam logic [2:0] DECAY = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]             state;
    logic [IW-1:0]          in_idx;
    logic [NW-1:0]          n_idx;
    logic [NUM_INPUTS-1:0]  spk_lat;
    logic [SIZE-1:0]        beta_q;
    logic [SIZE-1:0]        vth_q;
    logic [SIZE-1:0]        vmem [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] pend;
    logic [NUM_NEURONS-1:0] spk_next;
    logic                   cur_spk;
    logic                   last_n;
    logic                   fire;

    assign cur_spk = spk_lat[in_idx];
    assign last_n  = (n_idx == NW'(NUM_NEURONS-1));
    // pend carries an integrate overflow forward so the neuron fires regardless of threshold
    assign fire    = bus.dp_spike | pend[n_idx];

`ifdef NEURON_SCHED_SKIP_EN
    logic          first_found;
    logic          nxt_found;
    logic [IW-1:0] first_idx;
    logic [IW-1:0] nxt_idx;

    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        nxt_found   = 1'b0;
        nxt_idx     = '0;
        for (int i = NUM_INPUTS-1; i >= 0; i--) begin
            if (spikes_in[i]) begin
                first_found = 1'b1;
                first_idx   = IW'(i);
            end
            if (spk_lat[i] && (i > int'(in_idx))) begin
                nxt_found = 1'b1;
                nxt_idx   = IW'(i);
            end
        end
    end
`else
    logic last_in;
    assign last_in = (in_idx == IW'(NUM_INPUTS-1));
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_idx     <= '0;
            n_idx      <= '0;
            spk_lat    <= '0;
            beta_q     <= '0;
            vth_q      <= '0;
            pend       <= '0;
            spk_next   <= '0;
            spikes_out <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) vmem[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_vmem)
                        for (int i = 0; i < NUM_NEURONS; i++) vmem[i] <= '0;
                    if (start) begin
                        spk_lat <= spikes_in;
                        beta_q  <= beta;
                        vth_q   <= v_th;
                        pend    <= '0;
                        n_idx   <= '0;
`ifdef NEURON_SCHED_SKIP_EN
                        in_idx  <= first_idx;
                        state   <= first_found ? FETCH : DECAY;
`else
                        in_idx  <= '0;
                        state   <= FETCH;
`endif
                    end
                end
                FETCH: state <= EXEC;
                EXEC: begin
                    if (bus.dp_spike) begin
                        vmem[n_idx] <= '1;
                        pend[n_idx] <= 1'b1;
                    end else begin
                        vmem[n_idx] <= bus.dp_v_mem_out;
                    end
                    if (!last_n) begin
                        n_idx <= n_idx + 1'b1;
                        state <= FETCH;
                    end else begin
                        n_idx <= '0;
`ifdef NEURON_SCHED_SKIP_EN
                        if (nxt_found) begin
                            in_idx <= nxt_idx;
                            state  <= FETCH;
                        end else begin
                            state  <= DECAY;
                        end
`else
                        if (last_in) begin
                            state  <= DECAY;
                        end else begin
                            in_idx <= in_idx + 1'b1;
                            state  <= FETCH;
                        end
`endif
                    end
                end
                DECAY: begin
                    vmem[n_idx]     <= fire ? '0 : bus.dp_v_mem_out;
                    spk_next[n_idx] <= fire;
                    if (last_n) begin
                        n_idx <= '0;
                        state <= DONE;
                    end else begin
                        n_idx <= n_idx + 1'b1;
                    end
                end
                DONE: begin
                    spikes_out <= spk_next;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy        = (state == FETCH) || (state == EXEC) || (state == DECAY);
    assign done        = (state == DONE);
    assign bus.dp_beta = beta_q;
    assign bus.dp_v_th = vth_q;

    always_comb begin
        bus.weight_ren      = 1'b0;
        bus.weight_addr     = '0;
        bus.dp_weight       = '0;
        bus.dp_v_mem_in     = '0;
        bus.dp_function_sel = 1'b0;
        case (state)
            FETCH: begin
                if (cur_spk) begin
                    bus.weight_ren  = 1'b1;
                    bus.weight_addr = AW'(in_idx) * AW'(NUM_NEURONS) + AW'(n_idx);
                end
            end
            EXEC: begin
                bus.dp_v_mem_in = vmem[n_idx];
                bus.dp_weight   = cur_spk ? bus.weight_rdata : '0;
            end
            DECAY: begin
                bus.dp_function_sel = 1'b1;
                bus.dp_v_mem_in     = vmem[n_idx];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_neuron_scheduler.sv
// Bench for neuron_scheduler: weight SRAM and neuron models around the DUT, layer-level reference model.
module tb_neuron_scheduler;
    localparam int SIZE = 8;
    localparam int NI   = 16;
    localparam int NN   = 10;
    localparam int AW   = $clog2(NI*NN);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            clear_vmem = 1'b0;
    logic [NI-1:0]   spikes_in = '0;
    logic [SIZE-1:0] beta = '0;
    logic [SIZE-1:0] v_th = '0;
    logic            busy;
    logic            done;
    logic [NN-1:0]   spikes_out;

    neuron_scheduler_if #(.SIZE(SIZE), .AW(AW)) bus ();

    neuron_scheduler #(.SIZE(SIZE), .NUM_INPUTS(NI), .NUM_NEURONS(NN), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear_vmem(clear_vmem),
        .spikes_in(spikes_in), .beta(beta), .v_th(v_th),
        .busy(busy), .done(done), .spikes_out(spikes_out), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [SIZE-1:0] wmem [0:(1<<AW)-1];
    always @(posedge clk) if (bus.weight_ren) bus.weight_rdata <= wmem[bus.weight_addr];

    // Combinational neuron: add with carry-out as spike, or Q0.8 decay compared against threshold
    logic [15:0] prod;
    always_comb begin
        prod = 16'(bus.dp_v_mem_in) * 16'(bus.dp_beta);
        if (bus.dp_function_sel) begin
            bus.dp_v_mem_out = prod[15:8];
            bus.dp_spike     = (prod[15:8] > bus.dp_v_th);
        end else begin
            {bus.dp_spike, bus.dp_v_mem_out} = {1'b0, bus.dp_v_mem_in} + {1'b0, bus.dp_weight};
        end
    end

    int            n_assert = 0;
    int            n_fail = 0;
    int            m_vmem [NN];
    int            m_int [NN];
    logic [NN-1:0] m_spk;
    int            last_snoop [NN];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic [NI-1:0] sp, input int b, input int vt, input bit clr);
        for (int n = 0; n < NN; n++) begin
            int  v;
            int  d;
            bit  ovf;
            bit  f;
            if (clr) m_vmem[n] = 0;
            v   = m_vmem[n];
            ovf = 1'b0;
            for (int i = 0; i < NI; i++) begin
                if (sp[i]) begin
                    v = v + int'(wmem[i*NN + n]);
                    if (v > 255) begin
                        v   = 255;
                        ovf = 1'b1;
                    end
                end
            end
            m_int[n]  = v;
            d         = (v * b) / 256;
            f         = ovf || (d > vt);
            m_spk[n]  = f;
            m_vmem[n] = f ? 0 : d;
        end
    endtask

    task automatic run_step(input logic [NI-1:0] sp, input logic [7:0] b, input logic [7:0] vt,
                            input bit clr, input bit poke);
        int pop;
        int exp_lat;
        int lat;
        int done_cnt;
        int ren_cnt;
        int sn;
        int snoop [NN];
        model_step(sp, int'(b), int'(vt), clr);
        pop = $countones(sp);
`ifdef NEURON_SCHED_SKIP_EN
        exp_lat = 1 + 2*pop*NN + NN;
`else
        exp_lat = 1 + 2*NI*NN + NN;
`endif
        @(negedge clk);
        spikes_in  = sp;
        beta       = b;
        v_th       = vt;
        clear_vmem = clr;
        start      = 1'b1;
        lat = 0; done_cnt = 0; ren_cnt = 0; sn = 0;
        for (int n = 0; n < NN; n++) snoop[n] = -1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            start      = poke && (k == 5);
            clear_vmem = poke && (k == 5);
            spikes_in  = (poke && (k == 5)) ? ~sp : sp;
            if (bus.weight_ren) ren_cnt++;
            if (bus.dp_function_sel && sn < NN) begin
                snoop[sn] = int'(bus.dp_v_mem_in);
                sn++;
            end
            if (done) begin
                done_cnt++;
                lat = k;
                break;
            end
        end
        start = 1'b0; clear_vmem = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("ren_count", 32'(ren_cnt), 32'(pop*NN));
        check("decay_cycles", 32'(sn), 32'(NN));
        for (int n = 0; n < NN; n++) begin
            check("vmem_after_integrate", 32'(snoop[n]), 32'(m_int[n]));
            last_snoop[n] = snoop[n];
        end
        check("spikes_out", 32'(spikes_out), 32'(m_spk));
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int dn;
        for (int a = 0; a < (1<<AW); a++) wmem[a] = '0;
        for (int n = 0; n < NN; n++) m_vmem[n] = 0;
        m_spk = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_spikes_out", 32'(spikes_out), 32'd0);
        check("rst_weight_ren", 32'(bus.weight_ren), 32'd0);
        check("rst_weight_addr", 32'(bus.weight_addr), 32'd0);
        check("rst_dp_weight", 32'(bus.dp_weight), 32'd0);
        check("rst_dp_v_mem_in", 32'(bus.dp_v_mem_in), 32'd0);
        check("rst_dp_function_sel", 32'(bus.dp_function_sel), 32'd0);
        check("rst_dp_beta", 32'(bus.dp_beta), 32'd0);
        check("rst_dp_v_th", 32'(bus.dp_v_th), 32'd0);
        rst_n = 1'b1;

        run_step('0, 8'd0, 8'd0, 1'b0, 1'b0);
        check("zero_step_spikes", 32'(spikes_out), 32'd0);

        wmem[0] = 8'd100;
        wmem[1] = 8'd60;
        run_step(16'h0001, 8'd128, 8'd40, 1'b1, 1'b0);
        check("single_fire", 32'(spikes_out), 32'h001);
        run_step(16'h0000, 8'd128, 8'd40, 1'b0, 1'b0);
        check("fired_vmem_zero", 32'(last_snoop[0]), 32'd0);
        check("kept_vmem_30", 32'(last_snoop[1]), 32'd30);

        for (int a = 0; a < (1<<AW); a++) wmem[a] = '0;
        wmem[0]  = 8'd200;
        wmem[NN] = 8'd100;
        run_step(16'h0003, 8'd255, 8'd255, 1'b1, 1'b0);
        check("overflow_fire", 32'(spikes_out), 32'h001);
        check("overflow_saturate", 32'(last_snoop[0]), 32'd255);
        check("clear_with_start", 32'(last_snoop[1]), 32'd0);

        for (int a = 0; a < NI*NN; a++) wmem[a] = 8'($urandom_range(0, 40));
        run_step(16'hFFFF, 8'($urandom_range(64, 255)), 8'($urandom_range(0, 255)), 1'b1, 1'b1);
        run_step(16'h0000, 8'($urandom_range(64, 255)), 8'($urandom_range(0, 100)), 1'b0, 1'b1);

        @(negedge clk);
        spikes_in = 16'hFFFF; beta = 8'd200; v_th = 8'd10; start = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_spikes_out", 32'(spikes_out), 32'd0);
        rst_n = 1'b1;
        dn = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        check("midrst_quiet", 32'(dn), 32'd0);
        for (int n = 0; n < NN; n++) m_vmem[n] = 0;
        m_spk = '0;

        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < NI*NN; a++) wmem[a] = 8'($urandom_range(0, 90));
            run_step(16'($urandom & $urandom), 8'($urandom_range(32, 255)),
                     8'($urandom_range(0, 200)), ($urandom_range(0, 3) == 0), (it == 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
